// File: rtl/swb_pkg.sv
// Shared types and width helpers for the store write buffer.
package swb_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int AW_DEFAULT    = 32;
    localparam int DW_DEFAULT    = 32;

    // One buffered store: word address (byte offset dropped) plus data.
    typedef struct packed {
        logic [AW_DEFAULT-3:0] waddr;
        logic [DW_DEFAULT-1:0] data;
    } swb_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/swb_fwd_match.sv
// Priority matcher: youngest valid buffered store whose word address equals the load's.
module swb_fwd_match
    import swb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic [AW-3:0]             ent_waddr [DEPTH],
    input  logic [DW-1:0]             ent_data  [DEPTH],
    input  logic [ptr_w(DEPTH)-1:0]   rd_ptr,
    input  logic [cnt_w(DEPTH)-1:0]   count,
    input  logic [AW-3:0]             ld_waddr,
    output logic                      hit,
    output logic [DW-1:0]             fwd_data
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest; a later match overrides, so the youngest wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (ent_waddr[idx] == ld_waddr)) begin
                hit      = 1'b1;
                fwd_data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the core store port and the data-memory bus.
// Optional load forwarding is built only when STORE_WRITE_BUFFER_FWD_EN is defined.
module store_write_buffer
    import swb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hit,
    output logic [DW-1:0]              ld_fwd_data,
    output logic                       bus_valid,
    input  logic                       bus_ready,
    output logic [AW-1:0]              bus_addr,
    output logic [DW-1:0]              bus_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-3:0] mem_waddr [DEPTH];
    logic [DW-1:0] mem_data  [DEPTH];
    logic          enq;
    logic          deq;
    logic          drop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign bus_valid = !empty;
    assign bus_addr  = {mem_waddr[rd_ptr], 2'b00};
    assign bus_data  = mem_data[rd_ptr];

    // A full buffer still accepts a store when the head leaves in the same cycle.
    assign deq  = bus_valid && bus_ready;
    assign enq  = st_valid && (!full || deq);
    assign drop = st_valid && full && !deq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow <= 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_waddr[wr_ptr] <= st_addr[AW-1:2];
            mem_data[wr_ptr]  <= st_data;
        end
    end

`ifdef STORE_WRITE_BUFFER_FWD_EN
    logic unused_bits;
    assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

    swb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd_match (
        .ent_waddr (mem_waddr),
        .ent_data  (mem_data),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .ld_waddr  (ld_addr[AW-1:2]),
        .hit       (ld_hit),
        .fwd_data  (ld_fwd_data)
    );
`else
    logic unused_bits;
    assign unused_bits = ^{st_addr[1:0], ld_addr};

    assign ld_hit      = 1'b0;
    assign ld_fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed plus randomized bench for store_write_buffer against a queue-based reference model.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic [31:0] ld_fwd_data;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_addr;
    logic [31:0] bus_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    st_t  q[$];
    logic ovf_m = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .ld_fwd_data (ld_fwd_data),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_addr    (bus_addr),
        .bus_data    (bus_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic        hit_m;
        logic [31:0] fd_m;
        hit_m = 1'b0;
        fd_m  = '0;
        check({tag, ".count"}, 64'(count), 64'(q.size()));
        check({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
        check({tag, ".full"}, 64'(full), 64'(q.size() == DEPTH));
        check({tag, ".bus_valid"}, 64'(bus_valid), 64'(q.size() != 0));
        check({tag, ".overflow"}, 64'(overflow), 64'(ovf_m));
        if (q.size() != 0) begin
            check({tag, ".bus_addr"}, 64'(bus_addr), 64'({q[0].addr[31:2], 2'b00}));
            check({tag, ".bus_data"}, 64'(bus_data), 64'(q[0].data));
        end
`ifdef STORE_WRITE_BUFFER_FWD_EN
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr[31:2] == ld_addr[31:2]) begin
                hit_m = 1'b1;
                fd_m  = q[i].data;
                break;
            end
        end
        if (hit_m) check({tag, ".ld_fwd_data"}, 64'(ld_fwd_data), 64'(fd_m));
`else
        check({tag, ".ld_fwd_data"}, 64'(ld_fwd_data), 64'(fd_m));
`endif
        check({tag, ".ld_hit"}, 64'(ld_hit), 64'(hit_m));
    endtask

    // Drive one cycle's inputs, check the pre-edge outputs, then advance the model past the edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic r, input logic [31:0] la, input string tag);
        bit deq;
        bit enq;
        @(negedge clk);
        st_valid  = v;
        st_addr   = a;
        st_data   = d;
        bus_ready = r;
        ld_addr   = la;
        #1;
        check_state(tag);
        deq = (q.size() != 0) && r;
        enq = v && ((q.size() < DEPTH) || deq);
        if (v && !enq) ovf_m = 1'b1;
        if (deq) void'(q.pop_front());
        if (enq) q.push_back('{a, d});
    endtask

    task automatic do_reset(input int dly, input string tag);
        @(negedge clk);
        #(dly);
        reset = 1'b1;
        #1;
        q.delete();
        ovf_m = 1'b0;
        check_state(tag);
        check({tag, ".bv_now"}, 64'(bus_valid), 64'(0));
        check({tag, ".cnt_now"}, 64'(count), 64'(0));
        st_valid  = 1'b0;
        bus_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rl;
        #2;
        check_state("por");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, "idle");

        // single store, held, then drained
        cycle(1, 32'h54, 32'h7, 0, 0, "t2_st");
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, "t2_hold");
            check("t2_addr", 64'(bus_addr), 64'h54);
            check("t2_data", 64'(bus_data), 64'h7);
        end
        cycle(0, 0, 0, 1, 0, "t2_deq");
        cycle(0, 0, 0, 0, 0, "t2_after");
        check("t2_empty", 64'(bus_valid), 64'(0));

        // fill, overflow, drain in order
        for (int i = 0; i < 4; i++) cycle(1, 32'h50 + 32'(4 * i), 32'(i + 1), 0, 0, "t3_fill");
        cycle(1, 32'h60, 32'h99, 0, 0, "t3_drop");
        cycle(0, 0, 0, 0, 0, "t3_chk");
        check("t3_ovf", 64'(overflow), 64'(1));
        check("t3_cnt", 64'(count), 64'(4));
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, 0, "t3_drain");
        end
        cycle(0, 0, 0, 0, 0, "t3_done");

        // full with simultaneous store and dequeue, then pointer wrap
        do_reset(0, "t4_rst");
        for (int i = 0; i < 4; i++) cycle(1, 32'h20 + 32'(4 * i), 32'(i), 0, 0, "t4_fill");
        cycle(1, 32'h70, 32'hAA, 1, 0, "t4_both");
        cycle(0, 0, 0, 0, 0, "t4_chk");
        check("t4_cnt", 64'(count), 64'(4));
        check("t4_ovf", 64'(overflow), 64'(0));
        for (int i = 0; i < 2 * DEPTH; i++) cycle(1, 32'h80 + 32'(4 * i), 32'h100 + 32'(i), 1, 0, "t4_wrap");
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, "t4_drain");

        // forwarding from duplicate addresses
        cycle(1, 32'h40, 32'h1, 0, 0, "t5_s1");
        cycle(1, 32'h40, 32'h2, 0, 0, "t5_s2");
        cycle(0, 0, 0, 0, 32'h43, "t5_hit");
`ifdef STORE_WRITE_BUFFER_FWD_EN
        check("t5_hit_lit", 64'(ld_hit), 64'(1));
        check("t5_data_lit", 64'(ld_fwd_data), 64'h2);
`else
        check("t5_hit_lit", 64'(ld_hit), 64'(0));
`endif
        cycle(0, 0, 0, 0, 32'h44, "t5_miss");
        check("t5_miss_lit", 64'(ld_hit), 64'(0));

        // randomized traffic on a small address set
        for (int i = 0; i < 400; i++) begin
            ra = 32'h40 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            rl = 32'h40 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 3) != 0), ra, $urandom, 1'($urandom_range(0, 2) == 0), rl, "rnd");
        end

        // asynchronous reset mid-cycle with pending stores
        do_reset(0, "t6_pre");
        for (int i = 0; i < 3; i++) cycle(1, 32'h10 + 32'(4 * i), 32'(i), 0, 0, "t6_fill");
        cycle(0, 0, 0, 0, 0, "t6_chk");
        check("t6_cnt3", 64'(count), 64'(3));
        do_reset(3, "t6_rst");
        cycle(0, 0, 0, 0, 0, "t6_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
